mips_mem_arbiter: RTL

Shares the MIPS32 single-port synchronous memory between two requesters: the CPU datapath/controller (fetch and load/store) and a debug/program-loader port. It replaces direct hierarchical preloading of memory with a real write path. The CPU has priority, with bounded starvation of the debug port. A lock input gives the debug port exclusive access while a program is loaded before `start`.

---
 rtl/mips_arb_pkg.sv | 17 +
 rtl/mem_arb_pick.sv | 42 ++++
 rtl/mips_mem_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mips_arb_pkg.sv
// Shared encodings for the MIPS32 memory arbiter: slot owner codes,
// FSM states and default bus widths.
package mips_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_DBG  = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between CPU and debug port, with a saturating streak
// counter that bounds how long a waiting debug request can be starved.
module mem_arb_pick #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic idle,
    input  logic cpu_req,
    input  logic dbg_valid,
    input  logic dbg_lock,
    output logic grant_cpu,
    output logic grant_dbg
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] streak;
    logic          cpu_eligible;
    logic          starved;

    always_comb begin
        cpu_eligible = cpu_req & ~dbg_lock;
        starved      = (streak == SW'(STARVE_LIMIT));
        grant_dbg    = idle & dbg_valid & (dbg_lock | starved | ~cpu_eligible);
        grant_cpu    = idle & ~grant_dbg & cpu_eligible;
    end

    // Only IDLE cycles move the streak; RESP cycles hold it.
    always_ff @(posedge clk) begin
        if (reset) begin
            streak <= '0;
        end else if (idle) begin
            if (grant_dbg || !dbg_valid) begin
                streak <= '0;
            end else if (grant_cpu && !starved) begin
                streak <= streak + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Two-cycle shared access to the single-port MIPS32 memory for the CPU and
// a debug/program-loader port; CPU first, debug guaranteed by a streak limit.
module mips_mem_arbiter
    import mips_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dbg_valid,
    output logic              dbg_ready,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,
    input  logic              dbg_lock,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    arb_state_t state, state_next;
    logic [1:0] owner_next;
    logic       resp_we, resp_we_next;
    logic       grant_cpu, grant_dbg;
    logic       pick_idle;

    assign pick_idle = (state == ST_IDLE) && !reset;

    mem_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .clk       (clk),
        .reset     (reset),
        .idle      (pick_idle),
        .cpu_req   (cpu_req),
        .dbg_valid (dbg_valid),
        .dbg_lock  (dbg_lock),
        .grant_cpu (grant_cpu),
        .grant_dbg (grant_dbg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            owner   <= OWN_NONE;
            resp_we <= 1'b0;
        end else begin
            state   <= state_next;
            owner   <= owner_next;
            resp_we <= resp_we_next;
        end
    end

    // Outputs are forced low while reset is held so a dropped access never
    // produces an ack or read-valid pulse.
    always_comb begin
        state_next   = state;
        owner_next   = owner;
        resp_we_next = resp_we;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        dbg_ready    = 1'b0;
        cpu_ack      = 1'b0;
        dbg_rvalid   = 1'b0;
        cpu_rdata    = '0;
        dbg_rdata    = '0;
        if (!reset) begin
            unique case (state)
                ST_IDLE: begin
                    owner_next = OWN_NONE;
                    if (grant_dbg) begin
                        mem_en       = 1'b1;
                        mem_we       = dbg_we;
                        mem_addr     = dbg_addr;
                        mem_wdata    = dbg_wdata;
                        dbg_ready    = 1'b1;
                        owner_next   = OWN_DBG;
                        resp_we_next = dbg_we;
                        state_next   = ST_RESP;
                    end else if (grant_cpu) begin
                        mem_en       = 1'b1;
                        mem_we       = cpu_we;
                        mem_addr     = cpu_addr;
                        mem_wdata    = cpu_wdata;
                        owner_next   = OWN_CPU;
                        resp_we_next = cpu_we;
                        state_next   = ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (owner == OWN_CPU) begin
                        cpu_ack = 1'b1;
                        if (!resp_we) begin
                            cpu_rdata = mem_rdata;
                        end
                    end else if (owner == OWN_DBG && !resp_we) begin
                        dbg_rvalid = 1'b1;
                        dbg_rdata  = mem_rdata;
                    end
                    owner_next = OWN_NONE;
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_stall = cpu_req & ~cpu_ack;

endmodule
